// File: rtl/iecdrv_pkg.sv
// Shared types and widths for the IEC drive SD-port arbiter.
package iecdrv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_WAIT_ACK = 2'd1,
    ARB_XFER     = 2'd2
  } arb_state_t;

  localparam int unsigned MAX_DRIVES = 8;
  localparam int unsigned LBA_W      = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BADDR_W    = 9;
  localparam int unsigned WDOG_W     = 24;

endpackage

// File: rtl/iecdrv_rr_pick.sv
// Round-robin picker: first requester after 'last', scanning upward modulo NUM.
module iecdrv_rr_pick #(
  parameter int unsigned NUM = 4
) (
  input  logic [NUM-1:0]          req,
  input  logic [$clog2(NUM)-1:0]  last,
  output logic                    any,
  output logic [$clog2(NUM)-1:0]  idx
);

  localparam int unsigned IW = $clog2(NUM);

  logic [2*NUM-1:0] req_dbl;
  logic [NUM-1:0]   req_rot;
  int unsigned      start;
  int unsigned      pos;
  logic             found;

  // Rotate so slot last+1 sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    start   = (32'(last) + 32'd1) % NUM;
    req_dbl = {req, req};
    req_rot = NUM'(req_dbl >> start);
    pos     = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!found && req_rot[i]) begin
        pos   = i;
        found = 1'b1;
      end
    end
    any = found;
    idx = IW'((pos + start) % NUM);
  end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Shares one host SD sector port among NUM drive instances, one sector at a time.
module iecdrv_sd_arbiter
  import iecdrv_pkg::*;
#(
  parameter int unsigned       NUM     = 4,
  parameter logic [WDOG_W-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LBA_W*NUM-1:0]    dev_lba,
  input  logic [NUM-1:0]          dev_rd,
  input  logic [NUM-1:0]          dev_wr,
  output logic [NUM-1:0]          dev_ack,
  input  logic [BYTE_W*NUM-1:0]   dev_buff_din,
  output logic [NUM-1:0]          dev_buff_wr,
  output logic [BADDR_W-1:0]      dev_buff_addr,
  output logic [BYTE_W-1:0]       dev_buff_dout,
  output logic                    timeout_err,
  output logic [LBA_W-1:0]        sd_lba,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack,
  input  logic [BADDR_W-1:0]      sd_buff_addr,
  input  logic [BYTE_W-1:0]       sd_buff_dout,
  output logic [BYTE_W-1:0]       sd_buff_din,
  input  logic                    sd_buff_wr
);

  localparam int unsigned IW = $clog2(NUM);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q,  last_d;
  logic [LBA_W-1:0]  lba_q,   lba_d;
  logic              rd_q,    rd_d;
  logic              wr_q,    wr_d;
  logic              terr_q,  terr_d;
  logic [WDOG_W-1:0] wdog_q,  wdog_d;

  logic [NUM-1:0]    req;
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic [LBA_W-1:0]  pick_lba;
  logic              pick_rd;

  assign req = dev_rd | dev_wr;

  iecdrv_rr_pick #(.NUM(NUM)) u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Operands of the drive chosen by the picker; read wins when both are set
  always_comb begin
    pick_lba = '0;
    pick_rd  = 1'b0;
    for (int unsigned n = 0; n < NUM; n++) begin
      if (pick_idx == IW'(n)) begin
        pick_lba = dev_lba[LBA_W*n +: LBA_W];
        pick_rd  = dev_rd[n];
      end
    end
  end

  // Next-state logic: arbitration, ack wait with watchdog, transfer phase
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdog_d  = wdog_q;
    terr_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // A stale ack (e.g. after an abort) must fall before a new request goes out
        if (!sd_ack && pick_any) begin
          grant_d = pick_idx;
          lba_d   = pick_lba;
          rd_d    = pick_rd;
          wr_d    = ~pick_rd;
          wdog_d  = '0;
          state_d = ARB_WAIT_ACK;
        end
      end
      ARB_WAIT_ACK: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ARB_XFER;
        end else if (wdog_q == TIMEOUT - WDOG_W'(1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          terr_d  = 1'b1;
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      ARB_XFER: begin
        if (!sd_ack) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM - 1);
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      terr_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      terr_q  <= terr_d;
      wdog_q  <= wdog_d;
    end
  end

  // Ack and buffer strobes reach only the granted drive; dropped once back in IDLE
  always_comb begin
    dev_ack     = '0;
    dev_buff_wr = '0;
    for (int unsigned n = 0; n < NUM; n++) begin
      dev_ack[n]     = sd_ack & (grant_q == IW'(n)) & (state_q != ARB_IDLE);
      dev_buff_wr[n] = sd_buff_wr & sd_ack & (grant_q == IW'(n)) & (state_q == ARB_XFER);
    end
  end

  // Buffer read data from the granted drive
  always_comb begin
    sd_buff_din = '0;
    for (int unsigned n = 0; n < NUM; n++) begin
      if (grant_q == IW'(n)) begin
        sd_buff_din = dev_buff_din[BYTE_W*n +: BYTE_W];
      end
    end
  end

  assign dev_buff_addr = sd_buff_addr;
  assign dev_buff_dout = sd_buff_dout;
  assign sd_lba        = lba_q;
  assign sd_rd         = rd_q;
  assign sd_wr         = wr_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_iecdrv_sd_arbiter.sv
// Self-checking bench for iecdrv_sd_arbiter: directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_iecdrv_sd_arbiter;

  localparam int unsigned NUM = 4;
  localparam int unsigned TMO = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [32*NUM-1:0]   dev_lba;
  logic [NUM-1:0]      dev_rd, dev_wr, dev_ack, dev_buff_wr;
  logic [8*NUM-1:0]    dev_buff_din;
  logic [8:0]          dev_buff_addr;
  logic [7:0]          dev_buff_dout;
  logic                timeout_err;
  logic [31:0]         sd_lba;
  logic                sd_rd, sd_wr, sd_ack;
  logic [8:0]          sd_buff_addr;
  logic [7:0]          sd_buff_dout, sd_buff_din;
  logic                sd_buff_wr;

  int checks = 0;
  int errors = 0;
  int m_last;

  iecdrv_sd_arbiter #(.NUM(NUM), .TIMEOUT(24'(TMO))) dut (
    .clk           (clk),
    .reset         (reset),
    .dev_lba       (dev_lba),
    .dev_rd        (dev_rd),
    .dev_wr        (dev_wr),
    .dev_ack       (dev_ack),
    .dev_buff_din  (dev_buff_din),
    .dev_buff_wr   (dev_buff_wr),
    .dev_buff_addr (dev_buff_addr),
    .dev_buff_dout (dev_buff_dout),
    .timeout_err   (timeout_err),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_din   (sd_buff_din),
    .sd_buff_wr    (sd_buff_wr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Round-robin reference: first requester strictly after 'last', wrapping
  function automatic int exp_pick(input logic [NUM-1:0] req, input int last);
    int c;
    for (int i = 1; i <= NUM; i++) begin
      c = (last + i) % NUM;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Waits (bounded) for a host request; cnt = negedges elapsed
  task automatic wait_req(output bit ok, output int cnt);
    ok  = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (sd_rd || sd_wr) begin
        ok  = 1'b1;
        cnt = i;
        return;
      end
    end
  endtask

  // One complete host-side sector transaction expected to be granted to drive n
  task automatic do_xact(input int n, input int lat, input int ack_dly,
                         input int nbytes, input bit keep);
    bit             ok;
    int             cnt, own, other, bad;
    bit             exp_rd;
    logic [31:0]    lba_exp;
    logic [7:0]     d;
    logic [NUM-1:0] onehot;
    onehot  = NUM'(1) << n;
    exp_rd  = dev_rd[n];
    lba_exp = dev_lba[32*n +: 32];
    wait_req(ok, cnt);
    chk("req_seen", 32'(ok), 1);
    if (!ok) return;
    if (lat >= 0) chk("req_latency", cnt, lat);
    chk("sd_rd", 32'(sd_rd), 32'(exp_rd));
    chk("sd_wr", 32'(sd_wr), 32'(!exp_rd));
    chk("sd_lba", sd_lba, lba_exp);
    chk("ack_before", 32'(dev_ack), 0);
    dev_lba[32*n +: 32] = $urandom;
    for (int i = 0; i < ack_dly; i++) @(negedge clk);
    chk("lba_hold", sd_lba, lba_exp);
    chk("req_hold", 32'({sd_rd, sd_wr}), exp_rd ? 2 : 1);
    sd_ack = 1'b1;
    #1;
    chk("dev_ack", 32'(dev_ack), 32'(onehot));
    if (!keep) begin
      dev_rd[n] = 1'b0;
      dev_wr[n] = 1'b0;
    end
    @(negedge clk);
    chk("req_drop", 32'({sd_rd, sd_wr}), 0);
    chk("buff_din", 32'(sd_buff_din), 32'(dev_buff_din[8*n +: 8]));
    own = 0; other = 0; bad = 0;
    for (int k = 0; k < nbytes; k++) begin
      d            = 8'($urandom);
      sd_buff_addr = 9'(k);
      sd_buff_dout = d;
      sd_buff_wr   = exp_rd;
      #1;
      if (dev_buff_wr[n]) own++;
      if ((dev_buff_wr & ~onehot) != '0) other++;
      if (dev_buff_addr !== 9'(k) || dev_buff_dout !== d || dev_ack !== onehot) bad++;
      @(negedge clk);
    end
    sd_buff_wr = 1'b0;
    chk("buff_wr_own", own, exp_rd ? nbytes : 0);
    chk("buff_wr_other", other, 0);
    chk("buff_route", bad, 0);
    sd_ack = 1'b0;
    #1;
    chk("ack_fall", 32'(dev_ack), 0);
    m_last = n;
  endtask

  initial begin
    bit ok;
    int cnt, hi, terr, stale;
    logic [NUM-1:0] req, add;
    int n, op;

    reset        = 1'b1;
    dev_lba      = '0;
    dev_rd       = '0;
    dev_wr       = '0;
    dev_buff_din = '0;
    sd_ack       = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    sd_buff_wr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lba", sd_lba, 0);
    chk("rst_rd", 32'(sd_rd), 0);
    chk("rst_wr", 32'(sd_wr), 0);
    chk("rst_ack", 32'(dev_ack), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    reset  = 1'b0;
    m_last = NUM - 1;

    // All four read together: 0,1,2,3; drive 1 keeps requesting through its XFER
    for (int i = 0; i < NUM; i++) dev_lba[32*i +: 32] = 32'h100 + 32'(i);
    dev_rd = '1;
    do_xact(0, 1, 2, 4, 1'b0);
    do_xact(1, 2, 1, 4, 1'b1);
    do_xact(2, 2, 3, 4, 1'b0);
    do_xact(3, 2, 0, 4, 1'b0);
    do_xact(1, 2, 1, 4, 1'b0);

    // Single read from drive 0 with full 512-byte sector
    repeat (3) @(negedge clk);
    dev_lba[31:0] = 32'h10;
    dev_rd[0]     = 1'b1;
    do_xact(0, 1, 3, 512, 1'b0);

    // Write from drive 2: its buffer data is routed, no strobes to drives
    dev_buff_din          = '0;
    dev_buff_din[23:16]   = 8'hA5;
    dev_lba[95:64]        = 32'h2222;
    dev_wr[2]             = 1'b1;
    do_xact(2, 2, 2, 8, 1'b0);

    // Read and write both set on drive 1: read wins
    dev_rd[1] = 1'b1;
    dev_wr[1] = 1'b1;
    do_xact(1, 2, 1, 3, 1'b0);

    // Randomized traffic checked against the round-robin reference
    for (int it = 0; it < 30; it++) begin
      req = dev_rd | dev_wr;
      add = NUM'($urandom) & ~req;
      if (req == '0 && add == '0) add = NUM'(1) << $urandom_range(NUM - 1, 0);
      for (int dv = 0; dv < NUM; dv++) begin
        if (add[dv]) begin
          op                      = $urandom_range(2, 0);
          dev_lba[32*dv +: 32]    = $urandom;
          dev_buff_din[8*dv +: 8] = 8'($urandom);
          dev_rd[dv]              = (op != 1);
          dev_wr[dv]              = (op != 0);
        end
      end
      n = exp_pick(dev_rd | dev_wr, m_last);
      do_xact(n, 2, $urandom_range(8, 0), $urandom_range(8, 1), ($urandom_range(3, 0) == 0));
    end
    dev_rd = '0;
    dev_wr = '0;
    stale  = 0;
    repeat (4) begin
      @(negedge clk);
      if (sd_rd || sd_wr) stale++;
    end
    chk("no_spurious_req", stale, 0);

    // Watchdog: no ack for drive 3
    dev_lba[127:96] = 32'h3333;
    dev_rd[3]       = 1'b1;
    wait_req(ok, cnt);
    chk("tmo_req", 32'(ok), 1);
    hi   = ok ? 1 : 0;
    terr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err) terr++;
      if (sd_rd) hi++;
      else break;
    end
    chk("tmo_len", hi, TMO);
    sd_ack = 1'b1;
    #1;
    chk("late_ack_blocked", 32'(dev_ack), 0);
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (timeout_err) terr++;
      if (sd_rd || sd_wr || dev_ack != '0) stale++;
    end
    chk("tmo_pulse", terr, 1);
    chk("stale_ack_no_req", stale, 0);
    m_last = 3;
    sd_ack = 1'b0;
    do_xact(3, 1, 2, 2, 1'b0);

    // Reset while drive 2 is in XFER
    dev_lba[95:64] = 32'hCAFE0002;
    dev_rd[2]      = 1'b1;
    wait_req(ok, cnt);
    chk("rst_xfer_req", 32'(ok), 1);
    sd_ack    = 1'b1;
    dev_rd[2] = 1'b0;
    @(negedge clk);
    chk("rst_xfer_ack", 32'(dev_ack), 32'b0100);
    dev_rd[0] = 1'b1;
    dev_rd[2] = 1'b1;
    reset     = 1'b1;
    #1;
    chk("rst_async_rd", 32'(sd_rd), 0);
    chk("rst_async_wr", 32'(sd_wr), 0);
    chk("rst_async_ack", 32'(dev_ack), 0);
    chk("rst_async_lba", sd_lba, 0);
    @(negedge clk);
    reset  = 1'b0;
    m_last = NUM - 1;
    stale  = 0;
    repeat (3) begin
      @(negedge clk);
      if (sd_rd || sd_wr || dev_ack != '0) stale++;
    end
    chk("rst_stale_ack", stale, 0);
    sd_ack = 1'b0;
    do_xact(0, 1, 1, 2, 1'b0);
    do_xact(2, 2, 1, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
